// File: rtl/ysyx_24110026_pkg.sv
// Shared constants for the ysyx_24110026 core slice.
package ysyx_24110026_pkg;
  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_24110026_ifu_fifo.sv
// Synchronous FIFO with a registered head; storage is a plain array with
// registered read, so the head never depends combinationally on push data.
module ysyx_24110026_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  import ysyx_24110026_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, remain;
  logic [WIDTH-1:0] head_reg;
  logic             do_push, do_pop;

  assign full        = (count_reg == CW'(DEPTH));
  assign empty       = (count_reg == '0);
  assign count       = count_reg;
  assign head        = head_reg;
  assign do_push     = push && !flush && !full;
  assign do_pop      = pop && !flush && !empty;
  assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
  assign remain      = count_reg - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= remain + CW'(do_push);
      // Entry at rd_ptr_next already sits in mem unless the FIFO drains, in which case the push becomes head.
      if (remain == '0) begin
        if (do_push) head_reg <= push_data;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end
endmodule

// File: rtl/ysyx_24110026_ifu.sv
// Pipelined instruction fetch: credit-limited requests, PC tag queue for
// in-order responses, instruction buffer, and redirect with stale-drop.
module ysyx_24110026_ifu #(
  parameter int              XLEN       = ysyx_24110026_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(ysyx_24110026_pkg::RESET_PC),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                fetch_en,
  input  logic                                redirect_valid,
  input  logic [XLEN-1:0]                     redirect_pc,
  output logic                                imem_req_valid,
  input  logic                                imem_req_ready,
  output logic [XLEN-1:0]                     imem_req_addr,
  input  logic                                imem_rsp_valid,
  input  logic [ysyx_24110026_pkg::ILEN-1:0]  imem_rsp_data,
  output logic                                inst_valid,
  input  logic                                inst_ready,
  output logic [ysyx_24110026_pkg::ILEN-1:0]  inst_data,
  output logic [XLEN-1:0]                     inst_pc
);
  import ysyx_24110026_pkg::*;

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int EW  = XLEN + ILEN;

  logic            run_reg, pending_reg, stale_reg, stale_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next, hold_addr_reg;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]   fifo_count, outstanding, outstanding_next;
  logic            fifo_full, fifo_empty, tag_full, tag_empty;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   head_entry;
  logic [CW:0]     in_use;
  logic            credit_ok, accept, req_stall, rsp_fire, rsp_drop, push, pop;

  // Buffered plus in-flight never exceeds depth, so every kept response has a slot.
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = !fifo_full && !tag_full && (in_use < CW1'(FIFO_DEPTH));

  assign imem_req_valid   = pending_reg || (run_reg && fetch_en && credit_ok);
  assign imem_req_addr    = pending_reg ? hold_addr_reg : fetch_pc_reg;
  assign accept           = imem_req_valid && imem_req_ready;
  assign req_stall        = imem_req_valid && !imem_req_ready;
  assign rsp_fire         = imem_rsp_valid && !tag_empty;
  assign rsp_drop         = rsp_fire && (drop_cnt_reg != '0);
  assign push             = rsp_fire && !rsp_drop && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  assign outstanding_next = outstanding + CW'(accept) - CW'(rsp_fire);

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    stale_next    = stale_reg;
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid) begin
      drop_cnt_next = outstanding_next;
      stale_next    = req_stall;
      fetch_pc_next = redirect_pc & ~XLEN'(3);
    end else begin
      // A stale request was issued for the old path: drop its response and keep the redirect PC.
      drop_cnt_next = drop_cnt_reg - CW'(rsp_drop) + CW'(accept && stale_reg);
      if (accept) begin
        stale_next = 1'b0;
        if (!stale_reg) fetch_pc_next = fetch_pc_reg + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg       <= 1'b0;
      pending_reg   <= 1'b0;
      stale_reg     <= 1'b0;
      hold_addr_reg <= RESET_PC;
      fetch_pc_reg  <= RESET_PC;
      drop_cnt_reg  <= '0;
    end else begin
      run_reg       <= 1'b1;
      pending_reg   <= req_stall;
      stale_reg     <= stale_next;
      hold_addr_reg <= imem_req_addr;
      fetch_pc_reg  <= fetch_pc_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

  ysyx_24110026_ifu_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (imem_req_addr),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head      (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  ysyx_24110026_ifu_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({tag_pc, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = head_entry[EW-1:ILEN];
  assign inst_data  = head_entry[ILEN-1:0];
endmodule

// File: doc/ysyx_24110026_ifu.md
Name: ysyx_24110026_ifu

Overview:
- Parametrised, pipelined instruction-fetch unit with its own PC; the successor to the combinational `pc+4` / `pc_ctrl` mux path in the core top.
- Issues word fetches to instruction memory over a valid/ready request channel and buffers in-order responses in a small FIFO.
- Hands {pc, inst} to decode over a valid/ready channel.
- Supports redirect (branch/jump/trap) with flush and discard of stale in-flight responses.
- Fetch can be paused; decode backpressure is absorbed by the FIFO.

Parameters:
- XLEN, 32, width of PC, addresses and instruction data.
- RESET_PC, 32'h80000000, fetch PC after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- fetch_en  in  1  permits new requests; in-flight responses are still accepted when low.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] forced to 0 internally.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word address of the request.
- imem_rsp_valid  in  1  response valid; in-order, never backpressured.
- imem_rsp_data  in  32  fetched instruction.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts the head entry.
- inst_data  out  32  head instruction.
- inst_pc  out  XLEN  PC of head instruction.

Behaviour:
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0. FIFO empty; outstanding=0, drop_cnt=0, stale=0, fetch_pc=RESET_PC. Reset mid-operation discards everything; responses arriving after reset deassertion are ignored only if drop_cnt covers them, so the memory must also be reset.
- Credit rule: imem_req_valid asserts when fetch_en && (fifo_count + outstanding) < FIFO_DEPTH. This guarantees every non-dropped response has a free slot.
- Request stability: once imem_req_valid=1 and imem_req_ready=0, valid and addr hold unchanged until accepted. This holds even across redirect or fetch_en falling.
- On accept (valid && ready): outstanding+1, fetch_pc += 4 (wraps modulo 2^XLEN). The PC of each accepted request is queued alongside, in a PC shadow FIFO of FIFO_DEPTH, to tag its response.
- Response: if drop_cnt>0, discard it and decrement drop_cnt. Otherwise push {pc, data} into the FIFO. Either way outstanding decrements.
- Maximum issue rate is 1 request/cycle. Minimum latency: request accepted in cycle N, response in N+1, inst_valid in N+2 (registered FIFO output; no rsp→inst combinational path).
- Pop on inst_valid && inst_ready. Simultaneous push and pop while full is impossible by credit; push and pop while non-full are both performed.
- Redirect cycle:
  - An inst handshake in the same cycle completes (the consumer took it), then the FIFO clears.
  - A non-dropped response arriving in the same cycle is discarded and is not counted in drop_cnt.
  - drop_cnt ← outstanding after this cycle's accept/response updates, excluding the response just discarded.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - If a request is pending-unaccepted, set stale=1. On its later acceptance, drop_cnt+1, stale←0, and fetch_pc is not incremented.
  - inst_valid=0 in the following cycle.
- Back-to-back redirects: the latest wins. drop_cnt recomputes from outstanding, never accumulating beyond it.
- fetch_en low: no new requests; the FIFO drains normally; the PC holds.

Decomposition:
- Shared package ysyx_24110026_pkg holds XLEN, RESET_PC and the instruction width constant ILEN=32.
- Sub-module ysyx_24110026_ifu_fifo: synchronous FIFO of {XLEN pc, 32 data}, parametrised DEPTH. Ports: push, pop, flush, full, empty and count outputs; registered head.
- The PC tag queue reuses the same FIFO module at width XLEN.

Test Plan:
- Reset release, fetch_en=1, memory always ready with 1-cycle response of data=addr → inst stream pc 0x80000000, 0x80000004, 0x80000008… one per cycle, first inst_valid 2 cycles after first accept.
- inst_ready=0 for 10 cycles → exactly 4 requests issued, then imem_req_valid=0. On inst_ready=1, entries emerge in order with no loss or duplicate.
- 2 requests in flight, then redirect_pc=0x80001002 → the 2 responses are dropped; next inst_pc=0x80001000; no stale pc appears.
- imem_req_ready=0 with request at 0x80000010 held, redirect to 0x80000100 → addr stays 0x80000010 until accepted; its response is dropped; then requests continue from 0x80000100.
- Redirect in the same cycle as an inst handshake and a response → the handshake entry is consumed once; the response is discarded; drop_cnt matches remaining outstanding.
- fetch_pc=0xFFFFFFFC with XLEN=32 → the next request is at 0x00000000 (wrap).
